// File: rtl/fluxo_dados_noite_if.sv
// Strobe/status bundle between the night-phase control unit and its datapath.
interface fluxo_dados_noite_if #(
  parameter int unsigned N_JOG = 8
);
  localparam int unsigned JW = (N_JOG > 1) ? $clog2(N_JOG) : 1;

  logic          rst_global;
  logic          zera_CS;
  logic          inc_seed;
  logic          e_seed_reg;
  logic          zera_CJ;
  logic          inc_jogador;
  logic          mostra_classe;
  logic          CJ_fim;
  logic [JW-1:0] jogador_atual;
  logic [1:0]    classe;
  logic          classe_valida;
  logic          papeis_prontos;
  logic [7:0]    db_seed;

  modport master (
    output rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ, inc_jogador, mostra_classe,
    input  CJ_fim, jogador_atual, classe, classe_valida, papeis_prontos, db_seed
  );

  modport slave (
    input  rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ, inc_jogador, mostra_classe,
    output CJ_fim, jogador_atual, classe, classe_valida, papeis_prontos, db_seed
  );
endinterface

// File: rtl/fluxo_dados_noite.sv
// Night-phase datapath: seed counter/register, player counter and an LFSR-driven
// Fisher-Yates shuffle that deals roles (0 aldeao, 1 lobo, 2 vidente).
module fluxo_dados_noite #(
  parameter int unsigned N_JOG   = 8,
  parameter int unsigned N_LOBOS = 2
) (
  input logic                clock,
  input logic                reset,
  fluxo_dados_noite_if.slave bus
);
  localparam int unsigned JW = (N_JOG > 1) ? $clog2(N_JOG) : 1;
  localparam logic [JW-1:0] UltimoJog = JW'(N_JOG - 1);

  typedef enum logic [2:0] {StOcioso, StInicia, StSorteia, StTroca, StPronto} estado_e;

  estado_e       state_q, state_d;
  logic [7:0]    cs_q, cs_d;
  logic [7:0]    seed_q, seed_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    lfsr_step;
  logic [JW-1:0] cj_q, cj_d;
  logic [JW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [1:0]    table_q [N_JOG];
  logic [1:0]    table_d [N_JOG];

  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    cs_d = cs_q;
    if (bus.zera_CS)       cs_d = '0;
    else if (bus.inc_seed) cs_d = cs_q + 8'd1;

    cj_d = cj_q;
    if (bus.zera_CJ)                               cj_d = '0;
    else if (bus.inc_jogador && cj_q != UltimoJog) cj_d = cj_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    i_d     = i_q;
    j_d     = j_q;
    table_d = table_q;
    if (bus.rst_global) begin
      state_d = StOcioso;
      seed_d  = '0;
      for (int unsigned k = 0; k < N_JOG; k++) table_d[k] = 2'd0;
    end else if (bus.e_seed_reg) begin
      seed_d  = cs_q;
      state_d = StInicia;
    end else begin
      unique case (state_q)
        StOcioso: ;
        StInicia: begin
          for (int unsigned k = 0; k < N_JOG; k++) begin
            table_d[k] = (k < N_LOBOS) ? 2'd1 : ((k == N_LOBOS) ? 2'd2 : 2'd0);
          end
          // An all-zero LFSR would lock up, so seed 0 maps to 1.
          lfsr_d  = (seed_q == 8'd0) ? 8'h01 : seed_q;
          i_d     = UltimoJog;
          state_d = StSorteia;
        end
        StSorteia: begin
          lfsr_d = lfsr_step;
          if (lfsr_step[JW-1:0] <= i_q) begin
            j_d     = lfsr_step[JW-1:0];
            state_d = StTroca;
          end
        end
        StTroca: begin
          table_d[i_q] = table_q[j_q];
          table_d[j_q] = table_q[i_q];
          if (i_q == JW'(1)) begin
            state_d = StPronto;
          end else begin
            i_d     = i_q - 1'b1;
            state_d = StSorteia;
          end
        end
        StPronto: ;
        default: state_d = StOcioso;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StOcioso;
      cs_q    <= '0;
      seed_q  <= '0;
      lfsr_q  <= '0;
      cj_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      for (int unsigned k = 0; k < N_JOG; k++) table_q[k] <= 2'd0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      cj_q    <= cj_d;
      i_q     <= i_d;
      j_q     <= j_d;
      table_q <= table_d;
    end
  end

  assign bus.CJ_fim         = (cj_q == UltimoJog);
  assign bus.jogador_atual  = cj_q;
  assign bus.papeis_prontos = (state_q == StPronto);
  assign bus.classe_valida  = bus.mostra_classe && (state_q == StPronto);
  assign bus.classe         = bus.classe_valida ? table_q[cj_q] : 2'd0;
  assign bus.db_seed        = seed_q;
endmodule

// File: tb/tb_fluxo_dados_noite.sv
// Bench for fluxo_dados_noite: directed sequence plus random seeds, checked against a
// software Fisher-Yates model with rejection sampling.
module tb_fluxo_dados_noite;
  localparam int unsigned N_JOG   = 8;
  localparam int unsigned N_LOBOS = 2;
  localparam int          JW      = 3;
  localparam int          MASK    = (1 << JW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fluxo_dados_noite_if #(.N_JOG(N_JOG)) bus ();

  fluxo_dados_noite #(.N_JOG(N_JOG), .N_LOBOS(N_LOBOS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ref_tab  [N_JOG];
  int obs_tab  [N_JOG];
  int prev_tab [N_JOG];
  int ref_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Deal roles, then shuffle from the top index down; ref_lat counts clock edges
  // from the seed-load edge until the roles are ready.
  task automatic run_model(input int s);
    int l, j, t;
    for (int k = 0; k < N_JOG; k++) ref_tab[k] = (k < N_LOBOS) ? 1 : ((k == N_LOBOS) ? 2 : 0);
    l = (s == 0) ? 1 : s;
    ref_lat = 1;
    for (int i = N_JOG - 1; i >= 1; i--) begin
      do begin
        l = ((l << 1) & 255) | (((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1);
        ref_lat++;
        j = l & MASK;
      end while (j > i);
      t = ref_tab[i];
      ref_tab[i] = ref_tab[j];
      ref_tab[j] = t;
      ref_lat++;
    end
  endtask

  task automatic load_cs(input int n);
    bus.zera_CS = 1'b1;
    tick();
    bus.zera_CS = 1'b0;
    if (n > 0) begin
      bus.inc_seed = 1'b1;
      repeat (n) tick();
      bus.inc_seed = 1'b0;
    end
  endtask

  task automatic shuffle(input string tag, input int s, input bit watch);
    int cnt;
    run_model(s);
    bus.e_seed_reg = 1'b1;
    tick();
    bus.e_seed_reg = 1'b0;
    check({tag, "_db_seed"}, bus.db_seed, s & 255);
    check({tag, "_busy"}, bus.papeis_prontos, 0);
    cnt = 0;
    while (!bus.papeis_prontos && cnt < 4000) begin
      if (watch) begin
        check({tag, "_valida_busy"}, bus.classe_valida, 0);
        check({tag, "_classe_busy"}, bus.classe, 0);
      end
      tick();
      cnt++;
    end
    check({tag, "_ready"}, bus.papeis_prontos, 1);
    check({tag, "_latency"}, cnt, ref_lat);
    check({tag, "_latency_min"}, (cnt >= N_JOG) ? 1 : 0, 1);
  endtask

  task automatic read_table(input string tag);
    int nl, nv;
    nl = 0;
    nv = 0;
    bus.zera_CJ = 1'b1;
    tick();
    bus.zera_CJ = 1'b0;
    for (int k = 0; k < N_JOG; k++) begin
      check($sformatf("%s_cj%0d", tag, k), bus.jogador_atual, k);
      check($sformatf("%s_valida%0d", tag, k), bus.classe_valida, 1);
      check($sformatf("%s_classe%0d", tag, k), bus.classe, ref_tab[k]);
      obs_tab[k] = int'(bus.classe);
      if (obs_tab[k] == 1) nl++;
      if (obs_tab[k] == 2) nv++;
      if (k < N_JOG - 1) begin
        bus.inc_jogador = 1'b1;
        tick();
        bus.inc_jogador = 1'b0;
      end
    end
    check({tag, "_n_lobos"}, nl, N_LOBOS);
    check({tag, "_n_videntes"}, nv, 1);
  endtask

  initial begin
    int n;
    reset             = 1'b0;
    bus.rst_global    = 1'b0;
    bus.zera_CS       = 1'b0;
    bus.inc_seed      = 1'b0;
    bus.e_seed_reg    = 1'b0;
    bus.zera_CJ       = 1'b0;
    bus.inc_jogador   = 1'b0;
    bus.mostra_classe = 1'b1;

    #2;
    check("rst_CJ_fim", bus.CJ_fim, 0);
    check("rst_jogador", bus.jogador_atual, 0);
    check("rst_classe", bus.classe, 0);
    check("rst_valida", bus.classe_valida, 0);
    check("rst_prontos", bus.papeis_prontos, 0);
    check("rst_db_seed", bus.db_seed, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    load_cs(5);
    shuffle("seed5", 5, 1'b1);
    read_table("seed5");

    // Player counter: saturation and zera_CJ priority.
    bus.zera_CJ = 1'b1;
    tick();
    bus.zera_CJ = 1'b0;
    check("cj_zero", bus.jogador_atual, 0);
    check("cj_fim_zero", bus.CJ_fim, 0);
    for (int k = 1; k <= 8; k++) begin
      bus.inc_jogador = 1'b1;
      tick();
      bus.inc_jogador = 1'b0;
      check($sformatf("cj_inc%0d", k), bus.jogador_atual, (k > 7) ? 7 : k);
      check($sformatf("cj_fim_inc%0d", k), bus.CJ_fim, (k >= 7) ? 1 : 0);
    end
    bus.zera_CJ     = 1'b1;
    bus.inc_jogador = 1'b1;
    tick();
    bus.zera_CJ     = 1'b0;
    bus.inc_jogador = 1'b0;
    check("cj_zera_beats_inc", bus.jogador_atual, 0);
    check("cj_fim_after_zera", bus.CJ_fim, 0);

    // Seed 0 behaves as seed 1.
    load_cs(0);
    shuffle("seed0", 0, 1'b0);
    read_table("seed0");
    prev_tab = obs_tab;
    load_cs(1);
    shuffle("seed1", 1, 1'b0);
    read_table("seed1");
    for (int k = 0; k < N_JOG; k++) check($sformatf("seed0_eq_seed1_%0d", k), obs_tab[k],
                                           prev_tab[k]);

    // Restart mid-shuffle with CS counted up to 9.
    load_cs(5);
    bus.e_seed_reg = 1'b1;
    tick();
    bus.e_seed_reg = 1'b0;
    repeat (2) tick();
    bus.inc_seed = 1'b1;
    repeat (4) tick();
    bus.inc_seed = 1'b0;
    check("restart_midshuffle", bus.papeis_prontos, 0);
    shuffle("seed9", 9, 1'b0);
    read_table("seed9");

    // Asynchronous reset mid-shuffle.
    bus.zera_CJ = 1'b1;
    tick();
    bus.zera_CJ     = 1'b0;
    bus.inc_jogador = 1'b1;
    repeat (3) tick();
    bus.inc_jogador = 1'b0;
    load_cs(3);
    bus.e_seed_reg = 1'b1;
    tick();
    bus.e_seed_reg = 1'b0;
    repeat (3) tick();
    check("async_pre_seed", bus.db_seed, 3);
    check("async_pre_cj", bus.jogador_atual, 3);
    #2;
    reset = 1'b0;
    #1;
    check("async_jogador", bus.jogador_atual, 0);
    check("async_db_seed", bus.db_seed, 0);
    check("async_prontos", bus.papeis_prontos, 0);
    check("async_valida", bus.classe_valida, 0);
    check("async_classe", bus.classe, 0);
    check("async_CJ_fim", bus.CJ_fim, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // rst_global in PRONTO keeps CS and CJ.
    load_cs(7);
    shuffle("seed7", 7, 1'b0);
    bus.zera_CJ = 1'b1;
    tick();
    bus.zera_CJ     = 1'b0;
    bus.inc_jogador = 1'b1;
    repeat (4) tick();
    bus.inc_jogador = 1'b0;
    bus.rst_global  = 1'b1;
    tick();
    bus.rst_global = 1'b0;
    check("rstg_prontos", bus.papeis_prontos, 0);
    check("rstg_db_seed", bus.db_seed, 0);
    check("rstg_cj_kept", bus.jogador_atual, 4);
    check("rstg_valida", bus.classe_valida, 0);
    shuffle("rstg_cs_kept", 7, 1'b0);
    read_table("rstg_table");

    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(0, 255));
      load_cs(n);
      shuffle($sformatf("rand%0d", r), n, 1'b0);
      read_table($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fluxo_dados_noite.md
Name: fluxo_dados_noite

Overview:
Datapath partner of the night-phase control unit. It consumes that unit's control strobes (zera_CS, inc_seed, e_seed_reg, rst_global, zera_CJ, inc_jogador, mostra_classe) and returns CJ_fim. It holds the seed counter and seed register, and runs a sequential LFSR-driven Fisher-Yates shuffle that assigns roles to players. It also presents the current player's role during the night turn.

Parameters:
N_JOG, 8, number of players (2..256); JW = clog2(N_JOG), index width (JW must be 8 or less).
N_LOBOS, 2, number of werewolves (1..N_JOG-2).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rst_global  in  1  synchronous clear of seed register, role table and shuffle engine
zera_CS  in  1  synchronous clear of seed counter CS
inc_seed  in  1  CS <= CS+1 (8-bit, wraps 255->0)
e_seed_reg  in  1  seed <= CS; starts or restarts the shuffle
zera_CJ  in  1  synchronous clear of player counter CJ
inc_jogador  in  1  CJ <= CJ+1, saturates at N_JOG-1
mostra_classe  in  1  request display of role of player CJ
CJ_fim  out  1  CJ == N_JOG-1
jogador_atual  out  JW  CJ
classe  out  2  role of player CJ: 0 aldeao, 1 lobo, 2 vidente
classe_valida  out  1  mostra_classe & papeis_prontos
papeis_prontos  out  1  shuffle complete
db_seed  out  8  seed register

Behaviour:
- Reset (reset=0, asynchronous): CS=0, seed=0, CJ=0, LFSR=0, i=0, table all 0, engine state OCIOSO. Outputs: CJ_fim=0 (N_JOG>1), classe=0, classe_valida=0, papeis_prontos=0, db_seed=0.
- Priority per cycle: rst_global, then e_seed_reg, then engine step. zera_CS beats inc_seed. zera_CJ beats inc_jogador.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Step: l <= {l[6:0], l[7]^l[5]^l[4]^l[3]}. Period 255.
- Engine states:
  - OCIOSO: waits for e_seed_reg.
  - INICIA (1 cycle): table[k] = 1 for k < N_LOBOS; table[N_LOBOS] = 2; all other entries 0. Load LFSR = seed, or 8'h01 if seed is 0. Set i = N_JOG-1. Go to SORTEIA.
  - SORTEIA: step the LFSR. Let j = next_lfsr[JW-1:0]. If j <= i, latch j and go to TROCA. Otherwise stay in SORTEIA (rejection sampling). The nonzero LFSR guarantees eventual acceptance.
  - TROCA (1 cycle): swap table[i] and table[j]; j == i is a no-op. If i == 1, go to PRONTO; otherwise i <= i-1 and go to SORTEIA.
  - PRONTO: papeis_prontos=1 and hold. A new e_seed_reg goes to INICIA and clears papeis_prontos on the next edge.
- e_seed_reg in any state loads seed and enters INICIA on the next edge; this aborts any shuffle in progress.
- rst_global in any state forces OCIOSO and clears seed, table and papeis_prontos. It does not touch CS or CJ.
- The shuffle result is a pure function of seed and N_JOG. It always contains exactly N_LOBOS role-1 entries, one role-2 entry, and the rest role 0.
- classe = table[CJ] when classe_valida=1, else 0. This is combinational from registers, with zero latency after a CJ change.
- CJ_fim is combinational from CJ.
- Table and engine state are unaffected by zera_CJ and inc_jogador.

Test Plan:
- Reset release, then zera_CS, then inc_seed for 5 cycles, then e_seed_reg -> db_seed=5, papeis_prontos=0 for at least N_JOG cycles then 1. Final table matches a software model of LFSR seed 5; counts are 2 lobo, 1 vidente, 5 aldeao.
- Seed 0 (e_seed_reg straight after zera_CS) -> db_seed=0, LFSR starts at 8'h01, table matches the model for seed 1. Repeating with seed 1 gives an identical table.
- zera_CJ, then 7 inc_jogador -> CJ_fim rises exactly on the 7th increment with jogador_atual=7. An 8th increment keeps jogador_atual=7 and CJ_fim=1. zera_CJ together with inc_jogador -> jogador_atual=0.
- mostra_classe=1 during the shuffle -> classe_valida=0, classe=0. Once papeis_prontos=1, step CJ 0..7 -> classe_valida=1 and classe equals the model table at every index.
- Assert e_seed_reg with CS=9 mid-shuffle -> restart. Result equals the seed-9 model, not seed 5.
- reset=0 pulse mid-shuffle -> all outputs return to 0 immediately without waiting for a clock edge. rst_global while in PRONTO -> papeis_prontos=0 and db_seed=0 on the next edge, while CS and CJ are kept.
